mem_arbiter: RTL and testbench
==============================

# mem_arbiter

Two-requester arbiter for the single main-memory port. It sits between main memory and two clients: the instruction-fetch stage (read-only) and the executor's memory element (read and write). It serialises their transactions so at most one operation is outstanding at memory, and grants round-robin on contention. It routes each completion and its read data back to the originating client only.

## Interface
Parameters:
- ADDR_WIDTH, 32, address width of all ports
- DATA_WIDTH, 32, data width of all ports

Ports:
- clk  in  1  system clock; everything is clocked on its rising edge
- reset  in  1  synchronous, active-high reset
- fetch_addr  in  ADDR_WIDTH  fetch read address
- fetch_valid  in  1  fetch read request
- fetch_data  out  DATA_WIDTH  fetch read data, valid while fetch_ready=1
- fetch_ready  out  1  one-cycle fetch completion pulse
- exec_mem_in_addr / exec_mem_in_data  in  ADDR_WIDTH / DATA_WIDTH  executor write address/data
- exec_mem_in_valid  in  1  executor write request
- exec_mem_in_ready  out  1  one-cycle write completion pulse
- exec_mem_out_addr  in  ADDR_WIDTH  executor read address
- exec_mem_out_valid  in  1  executor read request
- exec_mem_out_data  out  DATA_WIDTH  executor read data, valid while exec_mem_out_ready=1
- exec_mem_out_ready  out  1  one-cycle read completion pulse
- main_mem_in_addr / main_mem_in_data  out  ADDR_WIDTH / DATA_WIDTH  memory write address/data
- main_mem_in_valid  out  1  memory write request
- main_mem_in_ready  in  1  memory write completion pulse
- main_mem_out_addr  out  ADDR_WIDTH  memory read address
- main_mem_out_valid  out  1  memory read request
- main_mem_out_data  in  DATA_WIDTH  memory read data, valid with main_mem_out_ready
- main_mem_out_ready  in  1  memory read completion pulse

## Operation
- Client handshake:
  - The client raises valid and holds valid, address and data stable until it sees its ready pulse.
  - It drops valid the cycle after ready.
- States: IDLE, F_RD, E_RD, E_WR, DONE.
- IDLE: sample requests and pick a winner.
  - Executor write and read both asserted: the executor candidate is the write (E_WR).
  - Fetch and executor both requesting: grant the client that is not `last_grant`, then update `last_grant`. `last_grant` resets to executor, so fetch wins the first tie.
  - Single requester: grant it.
  - No request: stay in IDLE.
- On a grant, register the winner's address (and data for a write) into main_mem_* and assert the matching main_mem_*_valid. Both are held constant until the memory ready pulse.
- F_RD / E_RD / E_WR: wait for main_mem_out_ready or main_mem_in_ready.
  - In the ready cycle, combinationally forward ready to the granted client. For reads, also forward main_mem_out_data.
  - Forward only if that client's valid is still high.
  - Deassert main_mem_*_valid and go to DONE.
- DONE: one turnaround cycle. Requests are ignored. Go to IDLE.
- Client drops valid mid-transaction (e.g. executor element reset): the memory operation still runs to completion. Its ready and data are discarded, not forwarded.
- Ungranted clients always see ready=0 and data=0.
- A memory ready pulse outside F_RD/E_RD/E_WR is ignored.

## Timing
- Reset values: state=IDLE; all main_mem_* outputs 0; all client ready/data outputs 0; last_grant=executor.
- reset high in any state (including mid-transaction): next cycle IDLE with every output 0. Memory is reset by the same signal.
- Request seen in IDLE at cycle N: main_mem_*_valid is high from cycle N+1.
- Memory ready at cycle M: client ready and data are high in cycle M (zero added latency). main_mem_*_valid is low from M+1. State is DONE at M+1 and IDLE at M+2.
- Minimum back-to-back spacing: memory ready at M allows the next grant's valid at M+3.
- main_mem_*_addr/data keep their last value after completion. They are 0 only after reset.

## Test plan
- Fetch only, addr 0x100, memory ready 2 cycles after valid with data 0xDEADBEEF:
  - main_mem_out_addr=0x100, valid asserted 1 cycle after fetch_valid.
  - fetch_ready pulses once with fetch_data=0xDEADBEEF; the executor ports stay 0.
- Fetch read 0x10 and executor write 0x20/0x55 in the same cycle after reset:
  - Fetch is granted first; the write issues after fetch completion plus DONE.
  - Each ready goes only to its owner.
- Fetch and executor read held continuously for 4 transactions: grants alternate F, E, F, E.
- Executor write and read asserted together: the write is issued first (main_mem_in_valid), then the read; each gets one ready pulse.
- Executor drops exec_mem_out_valid while E_RD is waiting:
  - main_mem_out_valid is held until memory ready.
  - exec_mem_out_ready stays 0; the next request is served after DONE.
- reset asserted 1 cycle into an F_RD grant: next cycle all outputs are 0 and the state is IDLE. A late memory ready is ignored.

Source files
------------

// File: rtl/mem_arbiter.sv
// Two-client arbiter for the single main-memory port: serialises instruction
// fetch reads and executor reads/writes, round-robin on contention.
module mem_arbiter #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-1:0] fetch_addr,
  input  logic                  fetch_valid,
  output logic [DATA_WIDTH-1:0] fetch_data,
  output logic                  fetch_ready,
  input  logic [ADDR_WIDTH-1:0] exec_mem_in_addr,
  input  logic [DATA_WIDTH-1:0] exec_mem_in_data,
  input  logic                  exec_mem_in_valid,
  output logic                  exec_mem_in_ready,
  input  logic [ADDR_WIDTH-1:0] exec_mem_out_addr,
  input  logic                  exec_mem_out_valid,
  output logic [DATA_WIDTH-1:0] exec_mem_out_data,
  output logic                  exec_mem_out_ready,
  output logic [ADDR_WIDTH-1:0] main_mem_in_addr,
  output logic [DATA_WIDTH-1:0] main_mem_in_data,
  output logic                  main_mem_in_valid,
  input  logic                  main_mem_in_ready,
  output logic [ADDR_WIDTH-1:0] main_mem_out_addr,
  output logic                  main_mem_out_valid,
  input  logic [DATA_WIDTH-1:0] main_mem_out_data,
  input  logic                  main_mem_out_ready
);

  typedef enum logic [2:0] {IDLE, F_RD, E_RD, E_WR, DONE} state_t;

  localparam logic GRANT_FETCH = 1'b0;
  localparam logic GRANT_EXEC  = 1'b1;

  state_t state, next_state;
  logic   last_grant, next_last_grant;
  logic   exec_req;
  state_t exec_candidate;

  // A pending executor write takes priority over its own read.
  assign exec_req       = exec_mem_in_valid | exec_mem_out_valid;
  assign exec_candidate = exec_mem_in_valid ? E_WR : E_RD;

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      last_grant <= GRANT_EXEC;
    end else begin
      state      <= next_state;
      last_grant <= next_last_grant;
    end
  end

  always_comb begin
    next_state      = state;
    next_last_grant = last_grant;
    case (state)
      IDLE: begin
        if (fetch_valid && exec_req) begin
          if (last_grant == GRANT_EXEC) begin
            next_state      = F_RD;
            next_last_grant = GRANT_FETCH;
          end else begin
            next_state      = exec_candidate;
            next_last_grant = GRANT_EXEC;
          end
        end else if (fetch_valid) begin
          next_state      = F_RD;
          next_last_grant = GRANT_FETCH;
        end else if (exec_req) begin
          next_state      = exec_candidate;
          next_last_grant = GRANT_EXEC;
        end
      end
      F_RD, E_RD: if (main_mem_out_ready) next_state = DONE;
      E_WR:       if (main_mem_in_ready)  next_state = DONE;
      DONE:       next_state = IDLE;
      default:    next_state = IDLE;
    endcase
  end

  // Memory-side request registers; address/data persist after completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      main_mem_in_addr   <= '0;
      main_mem_in_data   <= '0;
      main_mem_in_valid  <= 1'b0;
      main_mem_out_addr  <= '0;
      main_mem_out_valid <= 1'b0;
    end else if (state == IDLE) begin
      case (next_state)
        F_RD: begin
          main_mem_out_addr  <= fetch_addr;
          main_mem_out_valid <= 1'b1;
        end
        E_RD: begin
          main_mem_out_addr  <= exec_mem_out_addr;
          main_mem_out_valid <= 1'b1;
        end
        E_WR: begin
          main_mem_in_addr  <= exec_mem_in_addr;
          main_mem_in_data  <= exec_mem_in_data;
          main_mem_in_valid <= 1'b1;
        end
        default: ;
      endcase
    end else if (next_state == DONE) begin
      main_mem_in_valid  <= 1'b0;
      main_mem_out_valid <= 1'b0;
    end
  end

  // Completions go straight through, but only to a client still waiting.
  assign fetch_ready        = (state == F_RD) && main_mem_out_ready && fetch_valid;
  assign exec_mem_out_ready = (state == E_RD) && main_mem_out_ready && exec_mem_out_valid;
  assign exec_mem_in_ready  = (state == E_WR) && main_mem_in_ready && exec_mem_in_valid;
  assign fetch_data         = fetch_ready ? main_mem_out_data : '0;
  assign exec_mem_out_data  = exec_mem_out_ready ? main_mem_out_data : '0;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a latency-configurable memory model
// and an in-order scoreboard of expected client completions.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic [AW-1:0] fetch_addr;
  logic          fetch_valid;
  logic [DW-1:0] fetch_data;
  logic          fetch_ready;
  logic [AW-1:0] exec_mem_in_addr;
  logic [DW-1:0] exec_mem_in_data;
  logic          exec_mem_in_valid;
  logic          exec_mem_in_ready;
  logic [AW-1:0] exec_mem_out_addr;
  logic          exec_mem_out_valid;
  logic [DW-1:0] exec_mem_out_data;
  logic          exec_mem_out_ready;
  logic [AW-1:0] main_mem_in_addr;
  logic [DW-1:0] main_mem_in_data;
  logic          main_mem_in_valid;
  logic          main_mem_in_ready;
  logic [AW-1:0] main_mem_out_addr;
  logic          main_mem_out_valid;
  logic [DW-1:0] main_mem_out_data;
  logic          main_mem_out_ready;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .clk(clk), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_valid(fetch_valid),
    .fetch_data(fetch_data), .fetch_ready(fetch_ready),
    .exec_mem_in_addr(exec_mem_in_addr), .exec_mem_in_data(exec_mem_in_data),
    .exec_mem_in_valid(exec_mem_in_valid), .exec_mem_in_ready(exec_mem_in_ready),
    .exec_mem_out_addr(exec_mem_out_addr), .exec_mem_out_valid(exec_mem_out_valid),
    .exec_mem_out_data(exec_mem_out_data), .exec_mem_out_ready(exec_mem_out_ready),
    .main_mem_in_addr(main_mem_in_addr), .main_mem_in_data(main_mem_in_data),
    .main_mem_in_valid(main_mem_in_valid), .main_mem_in_ready(main_mem_in_ready),
    .main_mem_out_addr(main_mem_out_addr), .main_mem_out_valid(main_mem_out_valid),
    .main_mem_out_data(main_mem_out_data), .main_mem_out_ready(main_mem_out_ready)
  );

  // Memory model: answers each request after lat cycles; can be bypassed
  // so the bench drives ready/data by hand.
  logic          mem_en;
  int            lat;
  logic          model_out_ready, model_in_ready;
  logic [DW-1:0] model_out_data;
  logic          man_out_ready, man_in_ready;
  logic [DW-1:0] man_out_data;
  logic [DW-1:0] mem_store [0:255];
  logic [255:0]  mem_written;
  int            mcnt;
  logic          fired;

  assign main_mem_out_ready = mem_en ? model_out_ready : man_out_ready;
  assign main_mem_in_ready  = mem_en ? model_in_ready  : man_in_ready;
  assign main_mem_out_data  = mem_en ? model_out_data  : man_out_data;

  function automatic logic [DW-1:0] defaultRead(input logic [AW-1:0] a);
    return (a == 32'h100) ? 32'hDEADBEEF : ~a;
  endfunction

  always @(posedge clk) begin
    model_out_ready <= 1'b0;
    model_in_ready  <= 1'b0;
    model_out_data  <= 32'hBAD0BAD0;
    if (reset) begin
      mcnt        <= 0;
      fired       <= 1'b0;
      mem_written <= '0;
    end else if (main_mem_out_valid || main_mem_in_valid) begin
      if (!fired) begin
        if (mcnt >= lat - 1) begin
          fired <= 1'b1;
          mcnt  <= 0;
          if (main_mem_in_valid) begin
            model_in_ready <= 1'b1;
            mem_store[main_mem_in_addr[11:4]]   <= main_mem_in_data;
            mem_written[main_mem_in_addr[11:4]] <= 1'b1;
          end else begin
            model_out_ready <= 1'b1;
            model_out_data  <= mem_written[main_mem_out_addr[11:4]] ?
                               mem_store[main_mem_out_addr[11:4]] :
                               defaultRead(main_mem_out_addr);
          end
        end else begin
          mcnt <= mcnt + 1;
        end
      end
    end else begin
      fired <= 1'b0;
      mcnt  <= 0;
    end
  end

  // Scoreboard entries: owner mask {fetch, exec read, exec write} and data
  // expected on that owner's read-data port (0 for a write).
  typedef struct {
    logic [2:0]    mask;
    logic [DW-1:0] data;
  } exp_t;

  exp_t sb_q[$];
  int   vectors;
  int   miscompares;
  logic [2:0] mon_got;
  exp_t mon_e;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  task automatic pushExp(input logic [2:0] m, input logic [DW-1:0] d);
    exp_t e;
    e.mask = m;
    e.data = d;
    sb_q.push_back(e);
  endtask

  // Every completion must match the oldest expectation; idle data must be 0.
  always @(negedge clk) begin
    if (!reset) begin
      mon_got = {fetch_ready, exec_mem_out_ready, exec_mem_in_ready};
      if (mon_got != 3'b000) begin
        if (sb_q.size() == 0) begin
          checkOutput("sb_unexpected_ready", 32'(mon_got), 32'h0);
        end else begin
          mon_e = sb_q.pop_front();
          checkOutput("sb_owner", 32'(mon_got), 32'(mon_e.mask));
          checkOutput("sb_data", mon_got[2] ? fetch_data : exec_mem_out_data, mon_e.data);
        end
      end
      if (!fetch_ready)        checkOutput("fetch_data_zero", fetch_data, 32'h0);
      if (!exec_mem_out_ready) checkOutput("exec_data_zero", exec_mem_out_data, 32'h0);
    end
  end

  task automatic applyStimulus(input logic fv, input logic [AW-1:0] fa,
                               input logic wv, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                               input logic rv, input logic [AW-1:0] ra);
    fetch_valid        = fv;
    fetch_addr         = fa;
    exec_mem_in_valid  = wv;
    exec_mem_in_addr   = wa;
    exec_mem_in_data   = wd;
    exec_mem_out_valid = rv;
    exec_mem_out_addr  = ra;
  endtask

  task automatic doReset();
    reset = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    sb_q.delete();
  endtask

  // Clients drop valid the cycle after they see their ready.
  task automatic serveAll(input int budget);
    int   c;
    logic f, r, w;
    c = 0;
    while ((fetch_valid || exec_mem_in_valid || exec_mem_out_valid) && c < budget) begin
      @(negedge clk);
      f = fetch_ready;
      r = exec_mem_out_ready;
      w = exec_mem_in_ready;
      @(posedge clk);
      #1;
      if (f) fetch_valid = 1'b0;
      if (r) exec_mem_out_valid = 1'b0;
      if (w) exec_mem_in_valid = 1'b0;
      c++;
    end
    checkOutput("serve_timeout", 32'(fetch_valid || exec_mem_in_valid || exec_mem_out_valid), 32'h0);
    repeat (3) @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout observed=running required=finished");
    $fatal(1, "[TB] simulation time limit reached");
  end

  initial begin
    int n;
    int c;
    vectors       = 0;
    miscompares   = 0;
    mem_en        = 1'b1;
    lat           = 2;
    man_out_ready = 1'b0;
    man_in_ready  = 1'b0;
    man_out_data  = '0;
    reset         = 1'b1;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("rst_out_valid", 32'(main_mem_out_valid), 32'h0);
    checkOutput("rst_in_valid", 32'(main_mem_in_valid), 32'h0);
    checkOutput("rst_out_addr", main_mem_out_addr, 32'h0);
    checkOutput("rst_in_addr", main_mem_in_addr, 32'h0);
    checkOutput("rst_in_data", main_mem_in_data, 32'h0);
    checkOutput("rst_readies", 32'({fetch_ready, exec_mem_in_ready, exec_mem_out_ready}), 32'h0);
    reset = 1'b0;

    $display("[TB] fetch-only read at 0x100");
    doReset();
    pushExp(3'b100, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, '0);
    @(negedge clk);
    checkOutput("t1_valid_n", 32'(main_mem_out_valid), 32'h0);
    @(negedge clk);
    checkOutput("t1_valid_n1", 32'(main_mem_out_valid), 32'h1);
    checkOutput("t1_addr", main_mem_out_addr, 32'h100);
    @(negedge clk);
    checkOutput("t1_ready_early", 32'(fetch_ready), 32'h0);
    @(negedge clk);
    checkOutput("t1_ready", 32'(fetch_ready), 32'h1);
    checkOutput("t1_exec_idle", 32'({exec_mem_in_ready, exec_mem_out_ready, main_mem_in_valid}), 32'h0);
    @(posedge clk);
    #1 fetch_valid = 1'b0;
    @(negedge clk);
    checkOutput("t1_valid_drop", 32'(main_mem_out_valid), 32'h0);
    checkOutput("t1_addr_kept", main_mem_out_addr, 32'h100);
    checkOutput("t1_ready_once", 32'(fetch_ready), 32'h0);
    repeat (2) @(posedge clk);
    #1;

    $display("[TB] fetch vs executor write tie after reset");
    doReset();
    pushExp(3'b100, ~32'h10);
    pushExp(3'b001, 32'h0);
    applyStimulus(1'b1, 32'h10, 1'b1, 32'h20, 32'h55, 1'b0, '0);
    c = 0;
    do begin
      @(negedge clk);
      c++;
    end while (!fetch_ready && c < 20);
    checkOutput("t2_fetch_done", 32'(fetch_ready), 32'h1);
    @(posedge clk);
    #1 fetch_valid = 1'b0;
    @(negedge clk);
    checkOutput("t2_wr_m1", 32'(main_mem_in_valid), 32'h0);
    @(negedge clk);
    checkOutput("t2_wr_m2", 32'(main_mem_in_valid), 32'h0);
    @(negedge clk);
    checkOutput("t2_wr_m3", 32'(main_mem_in_valid), 32'h1);
    checkOutput("t2_wr_addr", main_mem_in_addr, 32'h20);
    checkOutput("t2_wr_data", main_mem_in_data, 32'h55);
    serveAll(20);

    $display("[TB] fetch and executor read held for four transactions");
    doReset();
    pushExp(3'b100, 32'hDEADBEEF);
    pushExp(3'b010, ~32'h10);
    pushExp(3'b100, 32'hDEADBEEF);
    pushExp(3'b010, ~32'h10);
    applyStimulus(1'b1, 32'h100, 1'b0, '0, '0, 1'b1, 32'h10);
    n = 0;
    c = 0;
    while (n < 4 && c < 80) begin
      @(negedge clk);
      if (fetch_ready || exec_mem_out_ready) n++;
      c++;
    end
    @(posedge clk);
    #1 applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b0, '0);
    checkOutput("t3_count", 32'(n), 32'h4);
    repeat (3) @(posedge clk);
    #1;

    $display("[TB] executor write and read together");
    doReset();
    pushExp(3'b001, 32'h0);
    pushExp(3'b010, 32'h1234);
    applyStimulus(1'b0, '0, 1'b1, 32'h40, 32'h1234, 1'b1, 32'h40);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t4_wr_first", 32'({main_mem_in_valid, main_mem_out_valid}), 32'h2);
    serveAll(40);

    $display("[TB] executor abandons read while waiting");
    doReset();
    lat = 5;
    applyStimulus(1'b0, '0, 1'b0, '0, '0, 1'b1, 32'h200);
    @(negedge clk);
    @(negedge clk);
    checkOutput("t5_valid", 32'(main_mem_out_valid), 32'h1);
    @(posedge clk);
    #1 exec_mem_out_valid = 1'b0;
    c = 0;
    @(negedge clk);
    while (!main_mem_out_ready && c < 20) begin
      checkOutput("t5_held", 32'(main_mem_out_valid), 32'h1);
      @(negedge clk);
      c++;
    end
    checkOutput("t5_mem_ready", 32'(main_mem_out_ready), 32'h1);
    checkOutput("t5_valid_at_ready", 32'(main_mem_out_valid), 32'h1);
    checkOutput("t5_no_fwd", 32'(exec_mem_out_ready), 32'h0);
    @(negedge clk);
    checkOutput("t5_valid_drop", 32'(main_mem_out_valid), 32'h0);
    lat = 2;
    @(posedge clk);
    #1;
    pushExp(3'b100, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, '0);
    serveAll(20);

    $display("[TB] reset during a fetch grant");
    doReset();
    mem_en = 1'b0;
    applyStimulus(1'b1, 32'h300, 1'b0, '0, '0, 1'b0, '0);
    @(posedge clk);
    #1;
    checkOutput("t6_granted", 32'(main_mem_out_valid), 32'h1);
    reset       = 1'b1;
    fetch_valid = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    checkOutput("t6_rst_valid", 32'(main_mem_out_valid), 32'h0);
    checkOutput("t6_rst_addr", main_mem_out_addr, 32'h0);
    man_out_ready = 1'b1;
    man_out_data  = 32'hCAFEF00D;
    @(negedge clk);
    checkOutput("t6_late_ready", 32'(fetch_ready), 32'h0);
    @(posedge clk);
    #1;
    man_out_ready = 1'b0;
    man_out_data  = '0;
    checkOutput("t6_still_idle", 32'(main_mem_out_valid), 32'h0);
    mem_en = 1'b1;
    @(posedge clk);
    #1;
    pushExp(3'b100, 32'hDEADBEEF);
    applyStimulus(1'b1, 32'h100, 1'b0, '0, '0, 1'b0, '0);
    serveAll(20);

    checkOutput("sb_drained", 32'(sb_q.size()), 32'h0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
